fetch_seq: RTL and testbench

//  Instruction-fetch sequencer on the control side of the 8-bit program counter. Each cycle it

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_decode.sv | 47 ++++
 rtl/fetch_seq.sv | 134 +++++++++++++
 tb/tb_fetch_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction-fetch sequencer.
//   - opcode values decoded from instr[IW-1:IW-3]
//   - FSM state encoding (IDLE is all-zero so a cleared register is a safe state)
//   - default instruction width
package fetch_pkg;

   localparam int IW_DEF = 9;

   localparam logic [2:0] OP_HALT = 3'b101;
   localparam logic [2:0] OP_BRF  = 3'b110;
   localparam logic [2:0] OP_BRB  = 3'b111;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_FETCH  = 3'd2;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_EXEC   = 3'd4;
   localparam logic [2:0] ST_HALTED = 3'd5;

endpackage

// File: rtl/fetch_decode.sv
// fetch_decode: combinational decode of the instruction register and latched
// branch flag into PC control requests.
//   ir_i        in  IW  instruction register
//   flag_i      in  1   flag latched alongside the instruction
//   branchf_o   out 1   taken forward branch
//   branchb_o   out 1   taken backward branch
//   target_o    out 8   relative target ({2'b0, offset}) for a taken branch, else 0
//   is_halt_o   out 1   instruction is HALT
module fetch_decode
   import fetch_pkg::*;
#(
   parameter int IW = IW_DEF
) (
   input  logic [IW-1:0] ir_i,
   input  logic          flag_i,
   output logic          branchf_o,
   output logic          branchb_o,
   output logic [7:0]    target_o,
   output logic          is_halt_o
);

   logic [2:0] opcode;
   logic [5:0] offset;

   assign opcode = ir_i[IW-1 -: 3];
   assign offset = ir_i[5:0];

   always_comb begin
      branchf_o = 1'b0;
      branchb_o = 1'b0;
      target_o  = 8'h00;
      is_halt_o = 1'b0;
      case (opcode)
         OP_BRF: if (flag_i) begin
            branchf_o = 1'b1;
            target_o  = {2'b00, offset};
         end
         OP_BRB: if (flag_i) begin
            branchb_o = 1'b1;
            target_o  = {2'b00, offset};
         end
         OP_HALT: is_halt_o = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer driving the control inputs of an
// always-incrementing 8-bit PC. Fetches one instruction at a time from
// instruction memory, resolves conditional relative branches, and stops on HALT.
//   clock_i, reset_i          clock, synchronous active-high reset
//   req_start_i, prog_start_i (re)start request and program start address
//   pc_i                      current PC value
//   stall_i                   datapath busy, holds off the next fetch
//   flag_i                    branch condition, latched with the instruction
//   imem_*                    instruction memory address / read / data / valid
//   start_o, startadd_o       PC load
//   branchf_o, branchb_o,
//   target_o                  PC relative step (branchb with target 0 = hold)
//   instr_o, instr_valid_o    instruction register and its EXEC pulse
//   halted_o                  sequencer stopped on HALT
//   instr_count_o             retired instruction count (wraps)
module fetch_seq
   import fetch_pkg::*;
#(
   parameter int IW    = IW_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             req_start_i,
   input  logic [7:0]       prog_start_i,
   input  logic [7:0]       pc_i,
   input  logic             stall_i,
   input  logic             flag_i,
   output logic [7:0]       imem_addr_o,
   output logic             imem_rd_o,
   input  logic [IW-1:0]    imem_data_i,
   input  logic             imem_valid_i,
   output logic             start_o,
   output logic [7:0]       startadd_o,
   output logic             branchf_o,
   output logic             branchb_o,
   output logic [7:0]       target_o,
   output logic [IW-1:0]    instr_o,
   output logic             instr_valid_o,
   output logic             halted_o,
   output logic [CNT_W-1:0] instr_count_o
);

   logic [2:0]       state, nxt_state;
   logic [7:0]       start_addr_q;
   logic [IW-1:0]    ir_q;
   logic             flag_q;
   logic             rd_q;
   logic [CNT_W-1:0] cnt_q;

   logic             dec_bf, dec_bb, dec_halt;
   logic [7:0]       dec_tgt;

   fetch_decode #(.IW(IW)) u_dec (
      .ir_i      (ir_q),
      .flag_i    (flag_q),
      .branchf_o (dec_bf),
      .branchb_o (dec_bb),
      .target_o  (dec_tgt),
      .is_halt_o (dec_halt)
   );

   // FETCH leaves once its read pulse has gone out. The pulse is a flop armed
   // from stall_i on the way into (or while sitting in) FETCH, which keeps
   // imem_rd_o free of any combinational path from stall_i while still giving
   // FETCH/WAIT/EXEC at three cycles per instruction.
   always_comb begin
      nxt_state = state;
      case (state)
         ST_IDLE:   nxt_state = ST_IDLE;
         ST_LOAD:   nxt_state = ST_FETCH;
         ST_FETCH:  if (rd_q) nxt_state = ST_WAIT;
         ST_WAIT:   if (imem_valid_i) nxt_state = ST_EXEC;
         ST_EXEC:   nxt_state = dec_halt ? ST_HALTED : ST_FETCH;
         ST_HALTED: nxt_state = ST_HALTED;
         default:   nxt_state = ST_IDLE;
      endcase
      // A restart abandons whatever is in flight, from any state.
      if (req_start_i) nxt_state = ST_LOAD;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state        <= ST_IDLE;
         start_addr_q <= 8'h00;
         ir_q         <= '0;
         flag_q       <= 1'b0;
         rd_q         <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state <= nxt_state;
         rd_q  <= (nxt_state == ST_FETCH) && !stall_i;
         if (req_start_i) start_addr_q <= prog_start_i;
         // Data is only accepted for the read we are waiting on; a restart in
         // the same cycle discards it.
         if (state == ST_WAIT && imem_valid_i && !req_start_i) begin
            ir_q   <= imem_data_i;
            flag_q <= flag_i;
         end
         if (state == ST_EXEC) cnt_q <= cnt_q + 1'b1;
      end
   end

   // PC control decode. The PC always steps +1 unless told otherwise, so every
   // state that must not move it asserts HOLD (backward branch by 0).
   always_comb begin
      start_o   = 1'b0;
      branchf_o = 1'b0;
      branchb_o = 1'b0;
      target_o  = 8'h00;
      case (state)
         ST_LOAD: start_o = 1'b1;
         ST_EXEC: begin
            if (dec_halt) begin
               branchb_o = 1'b1;
            end else begin
               branchf_o = dec_bf;
               branchb_o = dec_bb;
               target_o  = dec_tgt;
            end
         end
         default: branchb_o = 1'b1;
      endcase
   end

   assign imem_addr_o   = pc_i;
   assign imem_rd_o     = rd_q;
   assign startadd_o    = start_addr_q;
   assign instr_o       = ir_q;
   assign instr_valid_o = (state == ST_EXEC);
   assign halted_o      = (state == ST_HALTED);
   assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench: fetch_seq paired with a model of the free-running PC and a ROM with
// programmable read latency. Table of single-instruction vectors plus
// hand-written sequences for reset, stall, halt and restart-abandon cases.
module tb_fetch_seq;

   localparam int IW = 9;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_start;
   logic [7:0]    prog_start;
   logic [7:0]    pc_m = 8'h55;
   logic          stall;
   logic          flag;
   logic [7:0]    imem_addr;
   logic          imem_rd;
   logic [IW-1:0] imem_data = '0;
   logic          imem_valid = 1'b0;
   logic          start_o;
   logic [7:0]    startadd;
   logic          branchf, branchb;
   logic [7:0]    target;
   logic [IW-1:0] instr;
   logic          instr_valid;
   logic          halted;
   logic [CW-1:0] icount;

   always #5 clk = ~clk;

   fetch_seq #(.IW(IW), .CNT_W(CW)) dut (
      .clock_i       (clk),
      .reset_i       (rst),
      .req_start_i   (req_start),
      .prog_start_i  (prog_start),
      .pc_i          (pc_m),
      .stall_i       (stall),
      .flag_i        (flag),
      .imem_addr_o   (imem_addr),
      .imem_rd_o     (imem_rd),
      .imem_data_i   (imem_data),
      .imem_valid_i  (imem_valid),
      .start_o       (start_o),
      .startadd_o    (startadd),
      .branchf_o     (branchf),
      .branchb_o     (branchb),
      .target_o      (target),
      .instr_o       (instr),
      .instr_valid_o (instr_valid),
      .halted_o      (halted),
      .instr_count_o (icount)
   );

   // PC: no reset, no enable, +1 by default.
   always @(posedge clk) begin
      if (start_o)      pc_m <= startadd;
      else if (branchf) pc_m <= pc_m + target;
      else if (branchb) pc_m <= pc_m - target;
      else              pc_m <= pc_m + 8'd1;
   end

   // ROM: data valid 'lat' cycles after the read request.
   logic [IW-1:0] rom [256];
   int            lat = 1;
   int            rcnt = 0;
   always @(posedge clk) begin
      if (imem_rd) begin
         imem_data  <= rom[imem_addr];
         rcnt       <= lat - 1;
         imem_valid <= (lat == 1);
      end else if (rcnt != 0) begin
         rcnt       <= rcnt - 1;
         imem_valid <= (rcnt == 1);
      end else begin
         imem_valid <= 1'b0;
      end
   end

   int start_pulses = 0;
   always @(posedge clk) if (start_o) start_pulses <= start_pulses + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [7:0] a);
      prog_start = a;
      req_start  = 1'b1;
      tick();
      req_start  = 1'b0;
   endtask

   task automatic wait_exec(output bit ok);
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (instr_valid) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_rd(output bit ok);
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (imem_rd) begin
            ok = 1;
            break;
         end
         tick();
      end
   endtask

   typedef struct {
      logic [7:0]    addr;
      logic [IW-1:0] ins;
      logic          flg;
      logic          bf;
      logic          bb;
      logic [7:0]    tgt;
      logic [7:0]    nxt;
   } vec_t;

   vec_t vecs [9];

   initial begin
      bit ok;
      int exp_cnt;
      bit pc_ok;
      int rds;
      bit bad;

      vecs[0] = '{8'h10, 9'h000, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11}; // NOP
      vecs[1] = '{8'hFA, 9'h186, 1'b1, 1'b1, 1'b0, 8'h06, 8'h00}; // BRF 6 taken, wraps
      vecs[2] = '{8'hFA, 9'h186, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFB}; // BRF 6 not taken
      vecs[3] = '{8'h02, 9'h1C5, 1'b1, 1'b0, 1'b1, 8'h05, 8'hFD}; // BRB 5 taken, wraps
      vecs[4] = '{8'h02, 9'h1C5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03}; // BRB 5 not taken
      vecs[5] = '{8'h40, 9'h180, 1'b1, 1'b1, 1'b0, 8'h00, 8'h40}; // BRF 0 holds
      vecs[6] = '{8'h80, 9'h1FF, 1'b1, 1'b0, 1'b1, 8'h3F, 8'h41}; // BRB max offset
      vecs[7] = '{8'h30, 9'h0D5, 1'b1, 1'b0, 1'b0, 8'h00, 8'h31}; // other opcode
      vecs[8] = '{8'hF0, 9'h1BF, 1'b1, 1'b1, 1'b0, 8'h3F, 8'h2F}; // BRF max, wraps

      for (int i = 0; i < 256; i++) rom[i] = 9'h000;
      rst = 1'b1; req_start = 1'b0; prog_start = 8'h00; stall = 1'b0; flag = 1'b0;

      // Reset held 2 cycles
      tick(); tick();
      chk("rst_branchb", branchb, 1);
      chk("rst_target", target, 0);
      chk("rst_branchf", branchf, 0);
      chk("rst_start", start_o, 0);
      chk("rst_startadd", startadd, 0);
      chk("rst_rd", imem_rd, 0);
      chk("rst_instr", instr, 0);
      chk("rst_ivalid", instr_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_count", icount, 0);
      chk("rst_pc", pc_m, 8'h55);
      rst = 1'b0;
      tick(); tick();
      chk("idle_pc", pc_m, 8'h55);

      // NOP run from 8'h10
      start_pulses = 0;
      pulse_start(8'h10);
      for (int k = 0; k < 3; k++) begin
         wait_exec(ok);
         chk("nop_exec_seen", ok, 1);
         chk("nop_exec_pc", pc_m, 8'h10 + k);
         tick();
      end
      chk("nop_count", icount, 3);
      chk("nop_start_pulses", start_pulses, 1);
      exp_cnt = 3;

      // Table of single-instruction vectors
      for (int v = 0; v < 9; v++) begin
         rom[vecs[v].addr] = vecs[v].ins;
         flag = vecs[v].flg;
         pulse_start(vecs[v].addr);
         wait_exec(ok);
         chk("vec_exec_seen", ok, 1);
         chk("vec_exec_pc", pc_m, vecs[v].addr);
         chk("vec_instr", instr, vecs[v].ins);
         chk("vec_branchf", branchf, vecs[v].bf);
         chk("vec_branchb", branchb, vecs[v].bb);
         chk("vec_target", target, vecs[v].tgt);
         tick();
         exp_cnt++;
         chk("vec_count", icount, exp_cnt);
         wait_rd(ok);
         chk("vec_rd_seen", ok, 1);
         chk("vec_next_addr", imem_addr, vecs[v].nxt);
         rom[vecs[v].addr] = 9'h000;
      end
      flag = 1'b0;

      // Stall 4 cycles in FETCH, then 3-cycle memory latency
      lat = 3;
      stall = 1'b1;
      pulse_start(8'h50);
      tick();
      pc_ok = 1; rds = 0;
      for (int k = 0; k < 4; k++) begin
         if (pc_m != 8'h50) pc_ok = 0;
         if (imem_rd) rds++;
         tick();
      end
      stall = 1'b0;
      ok = 0;
      for (int k = 0; k < 30; k++) begin
         if (pc_m != 8'h50) pc_ok = 0;
         if (imem_rd) rds++;
         if (instr_valid) begin
            ok = 1;
            break;
         end
         tick();
      end
      chk("stall_exec_seen", ok, 1);
      chk("stall_pc_const", pc_ok, 1);
      chk("stall_rd_count", rds, 1);
      tick();
      exp_cnt++;
      chk("stall_count", icount, exp_cnt);
      lat = 1;

      // HALT at 8'h20
      rom[8'h20] = 9'h140;
      pulse_start(8'h20);
      wait_exec(ok);
      chk("halt_exec_seen", ok, 1);
      chk("halt_exec_hold", {branchf, branchb, target}, {1'b0, 1'b1, 8'h00});
      tick();
      exp_cnt++;
      chk("halt_halted", halted, 1);
      chk("halt_count", icount, exp_cnt);
      pc_ok = 1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (pc_m != 8'h20 || !halted) pc_ok = 0;
      end
      chk("halt_pc_held", pc_ok, 1);

      // Restart mid-WAIT: stale read must not execute
      rom[8'h60] = 9'h0C1;
      rom[8'h70] = 9'h191;
      lat = 4;
      pulse_start(8'h60);
      chk("abort_left_halt", halted, 0);
      wait_rd(ok);
      chk("abort_rd_seen", ok, 1);
      tick();                     // now in WAIT, data still 3 cycles out
      stall = 1'b1;
      pulse_start(8'h70);
      chk("abort_load", start_o, 1);
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (instr_valid || imem_rd) bad = 1;
      end
      chk("abort_no_stale_exec", bad, 0);
      chk("abort_count", icount, exp_cnt);
      lat = 1;
      stall = 1'b0;
      wait_exec(ok);
      chk("abort_exec_seen", ok, 1);
      chk("abort_exec_pc", pc_m, 8'h70);
      chk("abort_instr", instr, 9'h191);
      tick();
      exp_cnt++;
      chk("abort_final_count", icount, exp_cnt);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
